// File: rtl/fproc_pkg.sv
// Shared fproc definitions: state encoding of the measurement LUT front end.
package fproc_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOOKUP  = 2'd1,
        PRESENT = 2'd2
    } meas_lut_state_t;

    localparam int MEAS_LUT_N_MEAS_DEF  = 5;
    localparam int MEAS_LUT_N_CORES_DEF = 5;

endpackage

// File: rtl/fproc_lut_ram.sv
// Simple dual-port LUT storage: one write port, one registered read port, no reset.
module fproc_lut_ram
    import fproc_pkg::*;
#(
    parameter int AW = MEAS_LUT_N_MEAS_DEF,
    parameter int DW = MEAS_LUT_N_CORES_DEF
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    // Write and read share one edge, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fproc_meas_lut.sv
// Measurement LUT front end: gathers masked channel bits, looks up the LUT once all have
// reported and presents one result bit per core with a single-cycle lut_ready strobe.
module fproc_meas_lut
    import fproc_pkg::*;
#(
    parameter int N_MEAS  = MEAS_LUT_N_MEAS_DEF,
    parameter int N_CORES = MEAS_LUT_N_CORES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_MEAS-1:0]  meas,
    input  logic [N_MEAS-1:0]  meas_valid,
    input  logic [N_MEAS-1:0]  meas_mask,
    input  logic               clear,
    input  logic               lut_wr_en,
    input  logic [N_MEAS-1:0]  lut_wr_addr,
    input  logic [N_CORES-1:0] lut_wr_data,
    output logic [N_CORES-1:0] lut_out,
    output logic               lut_ready,
    output logic               busy,
    output logic               overrun
);

    localparam logic [N_MEAS-1:0]  MEAS_ZERO = {N_MEAS{1'b0}};

    meas_lut_state_t    state_q, state_d;
    logic [N_MEAS-1:0]  got_q, got_d;
    logic [N_MEAS-1:0]  bits_q, bits_d;
    logic [N_CORES-1:0] lut_out_q, lut_out_d;
    logic               lut_ready_q, lut_ready_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic [N_MEAS-1:0]  arr_s;
    logic [N_MEAS-1:0]  got_cov_s;
    logic [N_MEAS-1:0]  bits_merged_s;
    logic [N_MEAS-1:0]  snap_s;
    logic               fire_s;
    logic               dup_s;
    logic               rd_en_s;
    logic [N_CORES-1:0] rdata_s;

    // Same-cycle arrivals are merged so the last report can complete a round immediately.
    always_comb begin
        arr_s         = meas_valid & meas_mask;
        got_cov_s     = got_q | arr_s;
        bits_merged_s = (bits_q & ~arr_s) | (meas & arr_s);
        snap_s        = bits_merged_s & meas_mask;
        dup_s         = |(arr_s & got_q);
        fire_s        = (state_q == COLLECT) && (meas_mask != MEAS_ZERO) &&
                        ((got_cov_s & meas_mask) == meas_mask);
    end

    // The LUT is read in the fire cycle, so a same-cycle write to that address is not seen.
    fproc_lut_ram #(
        .AW (N_MEAS),
        .DW (N_CORES)
    ) u_lut_ram (
        .clk       (clk),
        .wr_en_i   (lut_wr_en),
        .wr_addr_i (lut_wr_addr),
        .wr_data_i (lut_wr_data),
        .rd_en_i   (rd_en_s),
        .rd_addr_i (snap_s),
        .rd_data_o (rdata_s)
    );

    // Next-state and output decode; clear overrides any arrival or fire in the same cycle.
    always_comb begin
        state_d     = state_q;
        got_d       = got_q;
        bits_d      = bits_q;
        lut_out_d   = lut_out_q;
        lut_ready_d = 1'b0;
        overrun_d   = overrun_q;
        rd_en_s     = 1'b0;
        if (clear) begin
            state_d   = COLLECT;
            got_d     = MEAS_ZERO;
            bits_d    = MEAS_ZERO;
            overrun_d = 1'b0;
        end else begin
            bits_d    = bits_merged_s;
            overrun_d = overrun_q | dup_s;
            case (state_q)
                COLLECT: begin
                    if (fire_s) begin
                        state_d = LOOKUP;
                        got_d   = MEAS_ZERO;
                        rd_en_s = 1'b1;
                    end else begin
                        got_d   = got_cov_s;
                    end
                end
                LOOKUP: begin
                    state_d     = PRESENT;
                    got_d       = got_cov_s;
                    lut_out_d   = rdata_s;
                    lut_ready_d = 1'b1;
                end
                PRESENT: begin
                    state_d = COLLECT;
                    got_d   = got_cov_s;
                end
                default: begin
                    state_d = COLLECT;
                    got_d   = MEAS_ZERO;
                end
            endcase
        end
        busy_d = (state_d != COLLECT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= COLLECT;
            got_q       <= MEAS_ZERO;
            bits_q      <= MEAS_ZERO;
            lut_out_q   <= {N_CORES{1'b0}};
            lut_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            got_q       <= got_d;
            bits_q      <= bits_d;
            lut_out_q   <= lut_out_d;
            lut_ready_q <= lut_ready_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign lut_out   = lut_out_q;
    assign lut_ready = lut_ready_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fproc_meas_lut.sv
// Directed self-checking bench for fproc_meas_lut.
module tb_fproc_meas_lut;

    logic       clk;
    logic       reset_n;
    logic [4:0] meas;
    logic [4:0] meas_valid;
    logic [4:0] meas_mask;
    logic       clear;
    logic       lut_wr_en;
    logic [4:0] lut_wr_addr;
    logic [4:0] lut_wr_data;
    logic [4:0] lut_out;
    logic       lut_ready;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    fproc_meas_lut dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .meas        (meas),
        .meas_valid  (meas_valid),
        .meas_mask   (meas_mask),
        .clear       (clear),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data),
        .lut_out     (lut_out),
        .lut_ready   (lut_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] v, input logic [4:0] m);
        meas_valid = v;
        meas       = m;
        step();
        meas_valid = 5'b00000;
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [4:0] d);
        lut_wr_en   = 1'b1;
        lut_wr_addr = a;
        lut_wr_data = d;
        step();
        lut_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        meas = 5'b00000; meas_valid = 5'b00000; meas_mask = 5'b00000;
        clear = 1'b0; lut_wr_en = 1'b0; lut_wr_addr = 5'b00000; lut_wr_data = 5'b00000;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (lut_out !== 5'b00000) begin n_fail++; $display("FAIL reset_lut_out: got %b want 00000", lut_out); end
        n_checks++; if (lut_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lut_ready: got %b want 0", lut_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        #2 reset_n = 1'b1;
        step();
        // LUT[a] = (7a+3) mod 32, with LUT[22] overridden
        for (int a = 0; a < 32; a++) begin
            lut_write(5'(a), 5'((a * 7 + 3) % 32));
        end
        lut_write(5'b10110, 5'b01011);
    endtask

    task automatic test_basic();
        meas_mask = 5'b11111;
        drive(5'b00011, 5'b00010);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_fire: busy %b want 0", busy); end
        drive(5'b01100, 5'b00100);
        drive(5'b10000, 5'b10000);
        n_checks++; if (lut_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_t1: ready %b busy %b want 0 1", lut_ready, busy); end
        step();
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b01011) begin n_fail++; $display("FAIL basic_t2: ready %b out %b want 1 01011", lut_ready, lut_out); end
        step();
        n_checks++; if (lut_ready !== 1'b0 || lut_out !== 5'b01011 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_t3: ready %b out %b busy %b want 0 01011 0", lut_ready, lut_out, busy); end
    endtask

    task automatic test_mask();
        meas_mask = 5'b00011;
        drive(5'b10011, 5'b10001);
        n_checks++; if (lut_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL mask_t1: ready %b busy %b want 0 1", lut_ready, busy); end
        step();
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b01010) begin n_fail++; $display("FAIL mask_out: ready %b out %b want 1 01010", lut_ready, lut_out); end
        step();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mask_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_back_to_back();
        meas_mask = 5'b11111;
        drive(5'b11111, 5'b11111);
        n_checks++; if (lut_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_t1: ready %b want 0", lut_ready); end
        drive(5'b00100, 5'b00100);
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b11100) begin n_fail++; $display("FAIL b2b_r1: ready %b out %b want 1 11100", lut_ready, lut_out); end
        step();
        n_checks++; if (lut_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_t3: ready %b busy %b want 0 0", lut_ready, busy); end
        drive(5'b11011, 5'b00000);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_r2_fire: busy %b want 1", busy); end
        step();
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b11111) begin n_fail++; $display("FAIL b2b_r2: ready %b out %b want 1 11111", lut_ready, lut_out); end
        step();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        meas_mask = 5'b00011;
        drive(5'b00001, 5'b00001);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %b want 0", overrun); end
        drive(5'b00001, 5'b00000);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
        drive(5'b00010, 5'b00010);
        step();
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b10001) begin n_fail++; $display("FAIL ovr_out: ready %b out %b want 1 10001", lut_ready, lut_out); end
        step();
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_clear();
        meas_mask = 5'b11111;
        drive(5'b11111, 5'b00000);
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++; if (lut_ready !== 1'b0 || lut_out !== 5'b10001 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_abort: ready %b out %b busy %b want 0 10001 0", lut_ready, lut_out, busy); end
        step();
        n_checks++; if (lut_ready !== 1'b0) begin n_fail++; $display("FAIL clr_no_ready: ready %b want 0", lut_ready); end
        // A partially collected round is dropped by clear.
        meas_mask = 5'b00011;
        drive(5'b00001, 5'b00000);
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive(5'b00010, 5'b00010);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_got: busy %b want 0", busy); end
        drive(5'b00001, 5'b00001);
        step();
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b11000 || overrun !== 1'b0) begin n_fail++; $display("FAIL clr_next_round: ready %b out %b ovr %b want 1 11000 0", lut_ready, lut_out, overrun); end
        step();
    endtask

    task automatic test_collision();
        meas_mask   = 5'b11111;
        lut_wr_en   = 1'b1;
        lut_wr_addr = 5'b10110;
        lut_wr_data = 5'b11110;
        drive(5'b11111, 5'b10110);
        lut_wr_en = 1'b0;
        step();
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b01011) begin n_fail++; $display("FAIL coll_old: ready %b out %b want 1 01011", lut_ready, lut_out); end
        step();
        drive(5'b11111, 5'b10110);
        step();
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b11110) begin n_fail++; $display("FAIL coll_new: ready %b out %b want 1 11110", lut_ready, lut_out); end
        step();
    endtask

    task automatic test_reset_mid();
        meas_mask = 5'b11111;
        drive(5'b11111, 5'b00000);
        reset_n = 1'b0;
        #1;
        n_checks++; if (lut_ready !== 1'b0 || lut_out !== 5'b00000 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid: ready %b out %b busy %b want 0 00000 0", lut_ready, lut_out, busy); end
        #3 reset_n = 1'b1;
        step();
        step();
        n_checks++; if (lut_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: ready %b busy %b want 0 0", lut_ready, busy); end
        drive(5'b11111, 5'b10110);
        step();
        n_checks++; if (lut_ready !== 1'b1 || lut_out !== 5'b11110) begin n_fail++; $display("FAIL rst_lut_kept: ready %b out %b want 1 11110", lut_ready, lut_out); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_back_to_back();
        test_overrun();
        test_clear();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
